shift_deser_rx: RTL



---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_deser_rx.sv | 113 +++++++++++
 2 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift link: receiver state encoding and
// the bit-order constants also used by the shift-register control logic.
package shift_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: accumulates WIDTH bits from a 1-bit stream and
// presents each completed word in a holding register on a valid/ready port.
module shift_deser_rx
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_din,
   input  logic             s_valid,
   input  logic             msb_first,
   input  logic             s_clear,
   output logic [WIDTH-1:0] p_dout,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             clr_ovr
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dir_q, dir_d;
   logic             vld_q, vld_d;
   logic             ovr_q, ovr_d;

   logic             dir_eff;
   logic [WIDTH-1:0] sh_shift;
   logic             complete;
   logic             handshake;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                 input logic             b,
                                                 input logic             dir);
      if (dir == DIR_MSB_FIRST) return {sh[WIDTH-2:0], b};
      else                      return {b, sh[WIDTH-1:1]};
   endfunction

   // Bit order is taken live on a frame's first bit, then frozen in dir_q.
   assign dir_eff   = (state_q == ST_IDLE) ? msb_first : dir_q;
   assign sh_shift  = shift_in(sh_q, s_din, dir_eff);
   assign handshake = vld_q && p_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      dir_d    = dir_q;
      dout_d   = dout_q;
      vld_d    = vld_q;
      ovr_d    = ovr_q;
      complete = 1'b0;

      if (s_clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (s_valid) begin
         sh_d  = sh_shift;
         dir_d = dir_eff;
         if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_SHIFT;
         end
      end

      // A word finishing while the consumer drains the old one loads directly.
      if (complete && (!vld_q || p_ready)) begin
         dout_d = sh_shift;
         vld_d  = 1'b1;
      end else if (handshake) begin
         vld_d = 1'b0;
      end

      if (clr_ovr) ovr_d = 1'b0;
      if (complete && vld_q && !p_ready) ovr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dir_q   <= DIR_LSB_FIRST;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   assign p_dout  = dout_q;
   assign p_valid = vld_q;
   assign busy    = (state_q == ST_SHIFT);
   assign overrun = ovr_q;

endmodule : shift_deser_rx
